// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared state encoding and word/address constants for the
//            instruction memory loader and its byte packer.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Loader FSM encoding, kept as plain constants for legacy tool flows
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Bytes packed into one instruction word
  localparam int unsigned BYTES_PER_WORD = 4;

  // Byte-address increment between consecutive instruction words
  localparam logic [31:0] WORD_ADDR_STEP = 32'd4;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_byte_packer
// Brief    : Little-endian byte-to-word packer. Each enabled byte lands in
//            the lane selected by a 2-bit counter; word_full flags the byte
//            that completes the current word.
// Revision : 1.0 - initial release
// ============================================================================
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0] lane;

  // The completing byte is the one arriving while the last lane is selected
  assign word_full = byte_en && (lane == LAST_LANE);

  // Lane counter and lane register; clear only rewinds the lane, so the
  // unwritten bytes of a new partial word keep whatever was there before
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane <= 2'd0;
      word <= 32'd0;
    end else if (clear) begin
      lane <= 2'd0;
    end else if (byte_en) begin
      word[{lane, 3'b000} +: 8] <= byte_data;
      lane                      <= lane + 2'd1;
    end
  end

endmodule : imem_byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Streams bytes over a valid/ready handshake, packs them into
//            32-bit little-endian words and writes them to the instruction
//            memory at consecutive word-aligned addresses starting at 0.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             we,
  output logic [31:0]      wa,
  output logic [31:0]      wd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_inc;
  logic             can_start;
  logic             len_zero;
  logic             len_too_big;
  logic             start_load;
  logic             byte_en;
  logic             word_full;

  // Handshake and status are decoded from the state register only, so the
  // write strobe never depends combinationally on byte_valid
  assign byte_ready = (state == ST_LOAD);
  assign we         = (state == ST_WRITE);
  assign busy       = (state == ST_LOAD) || (state == ST_WRITE);
  assign byte_en    = byte_valid && byte_ready;

  assign can_start   = (state == ST_IDLE) || (state == ST_DONE);
  assign len_zero    = (len_words == '0);
  assign len_too_big = (32'(len_words) > DEPTH_LIMIT);
  assign start_load  = start && can_start && !len_zero && !len_too_big;
  assign count_inc   = count + 1'b1;

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_load),
    .byte_en   (byte_en),
    .byte_data (byte_data),
    .word      (wd),
    .word_full (word_full)
  );

  // Load sequencer: start decode, byte collection, one-cycle write, address
  // and word counting
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      wa    <= 32'd0;
      len_q <= '0;
      count <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (len_zero) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b0;
            end else if (len_too_big) begin
              // Rejected load leaves the state untouched
              done <= 1'b0;
              err  <= 1'b1;
            end else begin
              state <= ST_LOAD;
              len_q <= len_words;
              wa    <= 32'd0;
              count <= '0;
              done  <= 1'b0;
              err   <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (word_full) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          count <= count_inc;
          if (count_inc == len_q) begin
            // Last word written; wa keeps the final address
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            wa    <= wa + WORD_ADDR_STEP;
            state <= ST_LOAD;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : imem_loader
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the instruction memory read port.
- Accepts a byte stream, for example from a UART or debug link, through a valid/ready handshake.
- Packs every 4 bytes little-endian into a 32-bit instruction and issues one-cycle write strobes to the instruction memory write port at word-aligned byte addresses from 0.
- Sits beside the core and runs before the core is released from reset to execute the loaded program.

Parameters:
- DEPTH_WORDS, 1024: instruction memory capacity in 32-bit words. Upper bound for a load.
- LEN_W, 16: width of the load-length input, in words.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous reset, active-low.
- start, input, 1: begin a load. Sampled only in IDLE or DONE.
- len_words, input, LEN_W: number of words to load. Sampled with start.
- byte_valid, input, 1: byte_data holds a valid byte.
- byte_data, input, 8: stream byte.
- byte_ready, output, 1: loader accepts a byte this cycle.
- we, output, 1: instruction memory write enable, one-cycle pulse.
- wa, output, 32: write byte address, always a multiple of 4.
- wd, output, 32: write data word.
- busy, output, 1: a load is in progress.
- done, output, 1: last load completed. Held high.
- err, output, 1: last start was rejected because len_words > DEPTH_WORDS. Held high.

Behaviour:
- Clock and reset: one clock, clk; synchronous active-low reset, rst.
- Reset values (when rst=0 at a clk edge): state=IDLE; byte_ready=0, we=0, wa=0, wd=0, busy=0, done=0, err=0; byte-lane counter=0; word counter=0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE, start=1:
  - len_words=0: go to DONE; done=1, err=0; no write.
  - len_words > DEPTH_WORDS: stay in current state; err=1, done=0.
  - Otherwise: go to LOAD; latch length, wa=0, lane=0, word count=0, done=0, err=0, busy=1.
- LOAD:
  - byte_ready=1. A byte transfers on a clk edge where byte_valid && byte_ready.
  - Byte k of a word (k=0..3) goes to wd[8k+7:8k], little-endian; lane increments.
  - On the 4th byte, lane wraps to 0 and state goes to WRITE.
- WRITE (exactly one cycle):
  - we=1 with stable wa/wd; byte_ready=0 (at most 4 bytes per 5 cycles).
  - Next edge: word count+1.
  - If count equals the latched length: go to DONE, busy=0, done=1, wa holds the last address.
  - Otherwise wa += 4 and return to LOAD.
- Latency: the 4th byte accepted at edge N gives we=1 in the cycle after edge N (registered, no combinational path from byte_valid to we).
- start while in LOAD or WRITE is ignored.
- byte_valid outside LOAD is ignored; no byte is consumed because byte_ready=0.
- An idle stream (byte_valid=0) stalls LOAD indefinitely with no timeout.
- wd bits not yet written in a partial word keep stale values; they are never written to memory before all 4 lanes are filled.
- Reset mid-operation discards any partial word and issues no write. The next load restarts at wa=0.
- Address arithmetic is 32-bit unsigned. The maximum wa is 4*(DEPTH_WORDS-1), so no wrap can occur.

Decomposition:
- Shared package:
  - state enum (IDLE, LOAD, WRITE, DONE);
  - constant BYTES_PER_WORD=4;
  - constant WORD_ADDR_STEP=4.
- One sub-module, imem_byte_packer:
  - 2-bit lane counter plus 32-bit lane register;
  - inputs: clk, rst, clear, byte_en, byte_data;
  - outputs: word, word_full.
- The top level holds the FSM, address counter and word counter.

Test Plan:
- Two-word load: len=2; bytes 13 05 00 00 93 05 10 00 with byte_valid held high.
  - Expect we at wa=0x0 with wd=0x00000513, then at wa=0x4 with wd=0x00100593.
  - Exactly 2 we pulses; done=1, busy=0.
- Backpressure gaps: same stream with 3-cycle byte_valid=0 gaps between bytes.
  - Identical writes, each we arriving 1 cycle after its 4th byte; no extra or duplicated bytes.
- Boundaries:
  - len=0: done=1 on the next cycle, zero we pulses.
  - len=DEPTH_WORDS+1: err=1, state stays IDLE, byte_ready stays 0.
- Reset mid-load: rst=0 after bytes AA BB are accepted, then restart with len=1 and bytes 01 02 03 04.
  - Single write at wa=0x0 with wd=0x04030201; no write of a partial word.
- start pulsed mid-LOAD (len=1 in progress):
  - Ignored; the load completes with 1 write; length and wa are not re-latched.
- Full-depth load with DEPTH_WORDS=4, len=4:
  - Writes at 0x0, 0x4, 0x8, 0xC; final wa=0xC; done=1.
